// File: rtl/ntt_butterfly_ct.sv
// Forward Cooley-Tukey NTT butterfly (Montgomery twiddle multiply), 5-stage pipeline, 1 set/cycle.
// Latency 5 cycles; a stalled output (out_valid & !out_ready) freezes every stage and drops in_ready.
module ntt_butterfly_ct #(
    parameter int QINV    = 62209,
    parameter int KYBER_Q = 3329,
    parameter int N_BFLY  = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] zeta_k,
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] o_a,
    output logic signed [15:0] o_b,
    output logic               busy,
    output logic               layer_done
);

    localparam int               CW       = (N_BFLY > 1) ? $clog2(N_BFLY) : 1;
    localparam logic [15:0]      QINV16   = 16'(QINV);
    localparam logic signed [31:0] KQ     = 32'(KYBER_Q);
    localparam logic [CW-1:0]    CNT_LAST = CW'(N_BFLY - 1);

    logic                r_v1, r_v2, r_v3, r_v4, r_v5;
    logic signed [31:0]  r_p1, r_p2, r_p3;
    logic signed [15:0]  r_a1, r_a2, r_a3, r_a4;
    logic signed [15:0]  r_u2;
    logic signed [31:0]  r_m3;
    logic signed [15:0]  r_r4;
    logic signed [15:0]  r_oa5, r_ob5;
    logic [CW-1:0]       r_cnt;

    logic                w_adv;
    logic                w_xfer;
    logic signed [31:0]  w_p;
    logic [15:0]         w_u;
    logic signed [31:0]  w_m;
    logic signed [31:0]  w_diff;
    logic signed [15:0]  w_r;

    assign w_adv  = !r_v5 | out_ready;
    assign w_xfer = r_v5 & out_ready;

    // Montgomery reduction split across S1..S4; only the low half of p matters for u.
    assign w_p    = 32'(zeta_k) * 32'(i_b);
    assign w_u    = r_p1[15:0] * QINV16;
    assign w_m    = 32'(r_u2) * KQ;
    assign w_diff = r_p3 - r_m3;
    assign w_r    = 16'(w_diff >>> 16);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_v4  <= 1'b0;
            r_v5  <= 1'b0;
            r_oa5 <= '0;
            r_ob5 <= '0;
            r_cnt <= '0;
        end else begin
            if (w_adv) begin
                r_v1  <= in_valid;
                r_v2  <= r_v1;
                r_v3  <= r_v2;
                r_v4  <= r_v3;
                r_v5  <= r_v4;
                r_oa5 <= r_a4 + r_r4;
                r_ob5 <= r_a4 - r_r4;
            end
            if (w_xfer) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
            end
        end
    end

    // Internal data stages need no reset: their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_p1 <= w_p;
            r_a1 <= i_a;
            r_p2 <= r_p1;
            r_u2 <= w_u;
            r_a2 <= r_a1;
            r_p3 <= r_p2;
            r_m3 <= w_m;
            r_a3 <= r_a2;
            r_r4 <= w_r;
            r_a4 <= r_a3;
        end
    end

    // Outputs are forced idle for the whole reset window, including its first cycle.
    assign in_ready   = w_adv | rst;
    assign out_valid  = r_v5 & !rst;
    assign busy       = !rst & (r_v1 | r_v2 | r_v3 | r_v4 | r_v5);
    assign layer_done = !rst & w_xfer & (r_cnt == CNT_LAST);
    assign o_a        = rst ? '0 : r_oa5;
    assign o_b        = rst ? '0 : r_ob5;

endmodule

// File: tb/tb_ntt_butterfly_ct.sv
// Bench for ntt_butterfly_ct: scoreboard fed at input transfers, monitor checks each output transfer.
module tb_ntt_butterfly_ct;

    localparam int QINV    = 62209;
    localparam int KYBER_Q = 3329;
    localparam int N_BFLY  = 128;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [15:0] zeta_k = '0;
    logic signed [15:0] i_a = '0;
    logic signed [15:0] i_b = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] o_a;
    logic signed [15:0] o_b;
    logic               busy;
    logic               layer_done;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   mon_xfers = 0;
    int   ld_pulses = 0;
    bit   held = 1'b0;
    logic signed [15:0] h_a, h_b;
    exp_t mon_e;
    bit   stim_done;

    ntt_butterfly_ct #(
        .QINV(QINV),
        .KYBER_Q(KYBER_Q),
        .N_BFLY(N_BFLY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .zeta_k(zeta_k),
        .i_a(i_a),
        .i_b(i_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o_a(o_a),
        .o_b(o_b),
        .busy(busy),
        .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: Montgomery product with plain 64-bit integer arithmetic.
    function automatic exp_t model(input logic signed [15:0] z, input logic signed [15:0] a,
                                   input logic signed [15:0] b);
        exp_t e;
        longint p, u, r;
        logic signed [15:0] t;
        p = longint'(z) * longint'(b);
        u = (p * QINV) & 64'hFFFF;
        if (u >= 32768) u = u - 65536;
        r = (p - u * KYBER_Q) >>> 16;
        t = r[15:0];
        e.a = a + t;
        e.b = a - t;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic signed [15:0] z, input logic signed [15:0] a,
                        input logic signed [15:0] b);
        int  waited = 0;
        bit  done = 1'b0;
        bit  rdy;
        zeta_k   = z;
        i_a      = a;
        i_b      = b;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                sb.push_back(model(z, a, b));
                done = 1'b1;
            end else if (++waited > 200) begin
                chk("send_timeout", waited, 0);
                done = 1'b1;
            end
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string nm, input logic signed [15:0] z, input logic signed [15:0] a,
                            input logic signed [15:0] b, input logic signed [15:0] ea,
                            input logic signed [15:0] eb);
        int lat = 0;
        wait_drain();
        out_ready = 1'b1;
        send(z, a, b);
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_o_a"}, o_a, ea);
        chk({nm, "_o_b"}, o_b, eb);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer, also checks hold and layer_done.
    always @(negedge clk) begin
        if (rst) begin
            mon_xfers = 0;
            ld_pulses = 0;
            held      = 1'b0;
        end else begin
            if (held) begin
                chk("hold_o_a", o_a, h_a);
                chk("hold_o_b", o_b, h_b);
            end
            if (out_valid && out_ready) begin
                chk("output_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    chk("o_a", o_a, mon_e.a);
                    chk("o_b", o_b, mon_e.b);
                end
                mon_xfers++;
                chk("layer_done_on_xfer", layer_done, (mon_xfers % N_BFLY) == 0);
                if (layer_done) ld_pulses++;
            end else begin
                chk("layer_done_idle", layer_done, 0);
            end
            held = out_valid && !out_ready;
            h_a  = o_a;
            h_b  = o_b;
        end
    end

    initial begin
        logic signed [15:0] zr;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_o_a", o_a, 0);
        chk("rst_o_b", o_b, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        directed("basic", 16'sd2285, 16'sd500, 16'sd100, 16'sd600, 16'sd400);
        directed("wrap", 16'sd2285, 16'sd32767, 16'sd100, -16'sd32669, 16'sd32667);
        zr = 16'($urandom);
        directed("b_zero", zr, -16'sd7, 16'sd0, -16'sd7, -16'sd7);

        // Ten-set stream with a three-cycle downstream stall in the middle.
        wait_drain();
        fork
            begin
                for (int k = 0; k < 10; k++) send(16'($urandom), 16'($urandom), 16'($urandom));
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with three operand sets in flight.
        for (int k = 0; k < 3; k++) send(16'($urandom), 16'($urandom), 16'($urandom));
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_busy", busy, 0);
        chk("postrst_out_valid", out_valid, 0);
        repeat (10) @(posedge clk);
        #1;

        // Two full layers back-to-back: layer_done on transfers 128 and 256 only.
        for (int k = 0; k < 2 * N_BFLY; k++) send(16'($urandom), 16'($urandom), 16'($urandom));
        wait_drain();
        chk("layer_pulses", ld_pulses, 2);

        // Random traffic with random input gaps and random backpressure.
        stim_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(16'($urandom), 16'($urandom), 16'($urandom));
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_butterfly_ct.md
NTT_BUTTERFLY_CT -- requirements
Module: ntt_butterfly_ct

Interface
REQ-001 SHALL have parameter QINV, default 62209, meaning q^-1 mod 2^16.
REQ-002 SHALL have parameter KYBER_Q, default 3329, meaning the Kyber modulus.
REQ-003 SHALL have parameter N_BFLY, default 128, meaning butterflies per NTT layer.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand set present.
REQ-007 SHALL have port in_ready  output  1  operand set accepted this cycle if in_valid.
REQ-008 SHALL have port zeta_k  input  16  signed twiddle, Montgomery domain.
REQ-009 SHALL have port i_a  input  16  signed coefficient r[j].
REQ-010 SHALL have port i_b  input  16  signed coefficient r[j+len].
REQ-011 SHALL have port out_valid  output  1  result pair present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port o_a  output  16  signed r[j] + t.
REQ-014 SHALL have port o_b  output  16  signed r[j] - t.
REQ-015 SHALL have port busy  output  1  any pipeline stage holds a valid operand set.
REQ-016 SHALL have port layer_done  output  1  one-cycle pulse on the N_BFLY-th output transfer.

Function
REQ-017 SHALL implement the forward (Cooley-Tukey) butterfly: t = mont(zeta_k*i_b); o_a = i_a + t; o_b = i_a - t.
REQ-018 SHALL compute mont(x) as: p = signed 32-bit zeta_k*i_b; u = low 16 bits of p*QINV, taken as signed; r = (p - u*KYBER_Q) arithmetic-shifted right 16; r is a 16-bit signed value.
REQ-019 SHALL form o_a and o_b in 16-bit two's complement with wrap-around and no saturation or final reduction.
REQ-020 SHALL be a 5-stage pipeline: S1 p; S2 u; S3 u*KYBER_Q; S4 r; S5 o_a/o_b. i_a is delayed alongside.
REQ-021 SHALL carry a valid bit per stage; out_valid is the S5 valid bit.
REQ-022 SHALL advance the whole pipeline when adv = !out_valid | out_ready, and SHALL hold every stage (data and valid) when adv = 0.
REQ-023 SHALL drive in_ready = adv combinationally; a transfer occurs when in_valid & in_ready.
REQ-024 SHALL insert a bubble into S1 when adv = 1 and in_valid = 0. Bubbles SHALL NOT be collapsed.
REQ-025 SHALL give latency of exactly 5 cycles from input transfer to out_valid when out_ready stays 1; throughput SHALL be one butterfly per cycle.
REQ-026 SHALL keep o_a/o_b stable while out_valid & !out_ready.
REQ-027 SHALL drive busy = OR of all stage valid bits.
REQ-028 SHALL count output transfers (out_valid & out_ready) in a counter of width clog2(N_BFLY).
REQ-029 SHALL pulse layer_done for one cycle on the transfer that makes the count reach N_BFLY, and SHALL wrap the counter to 0 in that same cycle.
REQ-030 SHALL handle a simultaneous input transfer and output transfer in one cycle with no loss or duplication.

Reset
REQ-031 SHALL, while rst = 1, clear all valid bits and the counter, and drive out_valid = 0, busy = 0, layer_done = 0, o_a = 0, o_b = 0.
REQ-032 SHALL, while rst = 1, drive in_ready = 1. No transfer is counted during reset.
REQ-033 SHALL discard all in-flight operands on reset mid-operation; no out_valid follows from them.

Verification
REQ-034 SHALL test: zeta_k=2285, i_a=500, i_b=100, out_ready=1 -> exactly 5 cycles later out_valid=1, o_a=600, o_b=400.
REQ-035 SHALL test: zeta_k=2285, i_a=32767, i_b=100 -> o_a=-32669 (wrap), o_b=32667.
REQ-036 SHALL test: zeta_k=arbitrary, i_b=0, i_a=-7 -> o_a=-7, o_b=-7.
REQ-037 SHALL test: a stream of 10 sets with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall; outputs appear in order, none lost or duplicated; results match a reference model.
REQ-038 SHALL test: 128 back-to-back transfers -> layer_done is high only on the 128th output transfer; the next 128 transfers pulse it again.
REQ-039 SHALL test: rst asserted with 3 sets in flight -> the next cycle has busy=0, out_valid=0; no stale outputs appear afterwards; the counter restarts at 0.
